// File: rtl/hex_scan_display.sv
// Time-multiplexed common-anode seven-segment driver: double-buffered hex input,
// leading-zero suppression, per-digit blanking and decimal points, per-slot dead time.
module hex_scan_display #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter int unsigned DEAD        = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4*DIGITS-1:0] value,
  input  logic                load,
  input  logic [DIGITS-1:0]   blank,
  input  logic [DIGITS-1:0]   dp,
  input  logic                lzs,
  input  logic                en,
  output logic [0:6]          seg,
  output logic                dp_n,
  output logic [DIGITS-1:0]   an_n,
  output logic                frame_start
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CntW-1:0] CntLast = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(DIGITS - 1);
  localparam logic [CntW-1:0] DeadCnt = CntW'(DEAD);

  // Nibble to active-low segments, bit order a..g from MSB to LSB.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Scan and buffer state
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_q, pend_d;
  logic [4*DIGITS-1:0] act_q, act_d;
  logic                pflag_q, pflag_d;

  // Registered outputs
  logic [0:6]          seg_q, seg_d;
  logic                dp_n_q, dp_n_d;
  logic [DIGITS-1:0]   an_n_q, an_n_d;
  logic                frame_start_q, frame_start_d;

  logic                cnt_wrap;
  logic                idx_wrap;
  logic                frame_end;

  always_comb begin
    cnt_wrap  = (cnt_q == CntLast);
    idx_wrap  = (idx_q == IdxLast);
    frame_end = cnt_wrap && idx_wrap;

    cnt_d = cnt_wrap ? '0 : cnt_q + CntW'(1);
    idx_d = idx_q;
    if (cnt_wrap) begin
      idx_d = idx_wrap ? '0 : idx_q + IdxW'(1);
    end

    // The transfer reads the old pend, so a load on the frame edge waits one more frame.
    pend_d  = load ? value : pend_q;
    act_d   = (frame_end && pflag_q) ? pend_q : act_q;
    pflag_d = load || (pflag_q && !frame_end);
  end

  logic [DIGITS-1:0] supp;
  logic              hi_zero;
  logic [3:0]        nib;
  logic              sel_blank;
  logic              sel_dp;
  logic              sel_supp;
  logic              dark;
  logic              past_dead;

  always_comb begin
    // A digit is suppressed when it and every more significant nibble are zero.
    hi_zero = 1'b1;
    supp    = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      hi_zero = hi_zero && (act_q[4*i +: 4] == 4'h0);
      supp[i] = lzs && hi_zero;
    end

    nib       = '0;
    sel_blank = 1'b0;
    sel_dp    = 1'b0;
    sel_supp  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = act_q[4*i +: 4];
        sel_blank = blank[i];
        sel_dp    = dp[i];
        sel_supp  = supp[i];
      end
    end

    dark      = sel_blank || sel_supp || !en;
    past_dead = (cnt_q >= DeadCnt);

    seg_d  = dark ? 7'b1111111 : hex_to_seg(nib);
    dp_n_d = dark || !sel_dp;

    an_n_d = '1;
    for (int i = 0; i < DIGITS; i++) begin
      if ((idx_q == IdxW'(i)) && !dark && past_dead) begin
        an_n_d[i] = 1'b0;
      end
    end

    frame_start_d = (cnt_q == '0) && (idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      pend_q        <= '0;
      act_q         <= '0;
      pflag_q       <= 1'b0;
      seg_q         <= '1;
      dp_n_q        <= 1'b1;
      an_n_q        <= '1;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      pend_q        <= pend_d;
      act_q         <= act_d;
      pflag_q       <= pflag_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp_n        = dp_n_q;
  assign an_n        = an_n_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_scan_display.sv
// Directed bench for hex_scan_display: per-digit expectations are queued when a value is
// loaded and popped slot by slot while the scanned outputs are sampled on the falling edge.
module tb_hex_scan_display;

  localparam int unsigned DIGITS      = 4;
  localparam int unsigned REFRESH_DIV = 8;
  localparam int unsigned DEAD        = 2;
  localparam int unsigned FRAME       = DIGITS * REFRESH_DIV;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value;
  logic        load;
  logic [3:0]  blank;
  logic [3:0]  dp;
  logic        lzs;
  logic        en;
  logic [0:6]  seg;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_start;

  typedef struct packed {
    logic       lit;
    logic [6:0] seg;
    logic       dp_n;
  } slot_t;

  slot_t exp_q[$];
  int    vectors     = 0;
  int    miscompares = 0;

  localparam logic [12:0] ResetObs = {1'b0, 4'hF, 7'b1111111, 1'b1};

  always #5 clk = ~clk;

  hex_scan_display #(
    .DIGITS     (DIGITS),
    .REFRESH_DIV(REFRESH_DIV),
    .DEAD       (DEAD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .load       (load),
    .blank      (blank),
    .dp         (dp),
    .lzs        (lzs),
    .en         (en),
    .seg        (seg),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_start(frame_start)
  );

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  function automatic logic [12:0] observed();
    return {frame_start, an_n, seg, dp_n};
  endfunction

  task automatic check(input string tag, input logic [12:0] obs, input logic [12:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed {fs,an_n,seg,dp_n}=%b required %b", tag, obs, expv);
    end
  endtask

  // Queue the four slot expectations of one frame showing v under the given controls.
  task automatic push_frame(input logic [15:0] v, input logic [3:0] bl, input logic [3:0] d,
                            input logic z, input logic e);
    for (int i = 0; i < 4; i++) begin
      slot_t       s;
      logic [15:0] hi;
      hi     = v >> (4 * i);
      s.lit  = e && !bl[i] && !(z && (i > 0) && (hi == 16'h0));
      s.seg  = s.lit ? ref_seg(v[4*i +: 4]) : 7'b1111111;
      s.dp_n = !(s.lit && d[i]);
      exp_q.push_back(s);
    end
  endtask

  // Entered on the falling edge where frame_start is high; leaves on the next such edge.
  task automatic check_frame(input string tag);
    for (int s = 0; s < 4; s++) begin
      slot_t e;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL %s: scoreboard empty at digit %0d, required 4 queued slots", tag, s);
        e = '{lit: 1'b0, seg: 7'b1111111, dp_n: 1'b1};
      end else begin
        e = exp_q.pop_front();
      end
      for (int k = 0; k < int'(REFRESH_DIV); k++) begin
        logic [3:0] an_e;
        if (s != 0 || k != 0) @(negedge clk);
        an_e = (e.lit && k >= int'(DEAD)) ? ~(4'b0001 << s) : 4'hF;
        check($sformatf("%s d%0d c%0d", tag, s, k), observed(),
              {(s == 0 && k == 0), an_e, e.seg, e.dp_n});
      end
    end
    @(negedge clk);
    check($sformatf("%s period", tag), {12'h0, frame_start}, 13'h1);
  endtask

  task automatic sync_frame(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < int'(2 * FRAME));
    check($sformatf("%s sync", tag), {12'h0, frame_start}, 13'h1);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    value = '0;
    load  = 1'b0;
    blank = '0;
    dp    = '0;
    lzs   = 1'b0;
    en    = 1'b1;
    repeat (3) @(negedge clk);
    check("in reset", observed(), ResetObs);
    rst_n = 1'b1;
    #1 check("first cycle after release", observed(), ResetObs);

    // First frame after reset shows act = 0.
    @(negedge clk);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_frame("boot");

    // 1: plain load
    pulse_load(16'h1A3F);
    sync_frame("t1");
    push_frame(16'h1A3F, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_frame("t1 1A3F");

    // 2: leading-zero suppression
    lzs = 1'b1;
    pulse_load(16'h0042);
    sync_frame("t2a");
    push_frame(16'h0042, 4'b0000, 4'b0000, 1'b1, 1'b1);
    check_frame("t2 0042");
    pulse_load(16'h0000);
    sync_frame("t2b");
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    check_frame("t2 0000");

    // 3: second load on the frame-start edge must wait a further frame
    lzs = 1'b0;
    pulse_load(16'h1111);
    repeat (29) @(negedge clk);
    pulse_load(16'h2222);
    sync_frame("t3");
    push_frame(16'h1111, 4'b0000, 4'b0000, 1'b0, 1'b1);
    push_frame(16'h2222, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_frame("t3 1111");
    check_frame("t3 2222");

    // 4: blanking and decimal points
    blank = 4'b0100;
    dp    = 4'b0101;
    sync_frame("t4");
    push_frame(16'h2222, 4'b0100, 4'b0101, 1'b0, 1'b1);
    check_frame("t4 blank/dp");
    blank = 4'b0000;
    dp    = 4'b0000;

    // 5: display disabled for 20 cycles, scanning continues
    en = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      check($sformatf("t5 off c%0d", c), observed(), ResetObs);
    end
    en = 1'b1;
    @(negedge clk);
    check("t5 resume c21", observed(), {1'b0, 4'b1011, 7'b0010010, 1'b1});
    for (int c = 22; c <= 32; c++) begin
      @(negedge clk);
      check($sformatf("t5 fs c%0d", c), {12'h0, frame_start}, {12'h0, (c == 32)});
    end
    push_frame(16'h2222, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_frame("t5 after");

    // 6: reset mid-slot with a load pending
    pulse_load(16'h5555);
    repeat (4) @(negedge clk);
    check("t6 lit before reset", observed(), {1'b0, 4'b1110, 7'b0010010, 1'b1});
    #2 rst_n = 1'b0;
    #1 check("t6 async reset", observed(), ResetObs);
    @(negedge clk);
    check("t6 held reset", observed(), ResetObs);
    rst_n = 1'b1;
    @(negedge clk);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    push_frame(16'h0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    check_frame("t6 frame0");
    check_frame("t6 frame1");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hex_scan_display.md
# hex_scan_display

Parametrised, time-multiplexed driver for a bank of common-anode seven-segment digits: it takes one hex nibble per digit and scans the digits at a programmable refresh rate. Segment and digit-select outputs are registered. The block adds these features:
- tear-free double-buffered value loading,
- per-digit blanking and decimal points,
- optional leading-zero suppression,
- a dead-time guard against ghosting.

It sits between any value-producing logic (counters, ALU results, debug registers) and the board's shared segment bus.

## Interface
Parameters:
- DIGITS, 4, number of scanned digits; legal range 1..8.
- REFRESH_DIV, 50000, clock cycles per digit slot; must be ≥ 2.
- DEAD, 16, cycles at the start of each slot with all digits off; must be < REFRESH_DIV.

Ports (clock and reset are one clock; reset is asynchronous and active-low):
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- value  in  4*DIGITS  hex nibbles; value[4i+3:4i] is digit i; digit 0 is least significant.
- load  in  1  capture `value` into the pending buffer this edge.
- blank  in  DIGITS  bit i = 1 forces digit i dark; sampled live.
- dp  in  DIGITS  bit i = 1 lights the decimal point of digit i; sampled live.
- lzs  in  1  leading-zero suppression enable; sampled live.
- en  in  1  display enable; 0 forces all outputs inactive while scanning continues.
- seg  out  [0:6]  active-low segments; seg[0]=a … seg[6]=g.
- dp_n  out  1  active-low decimal point.
- an_n  out  DIGITS  active-low digit select; at most one bit low.
- frame_start  out  1  one-cycle pulse on the first cycle of each digit-0 slot.

## Operation
- **Slot counter.** `cnt` counts 0..REFRESH_DIV-1 and wraps. On wrap, `idx` advances by one, wrapping from DIGITS-1 to 0. With DIGITS=1, `idx` stays 0.
- **Double buffer.** `load=1` copies `value` into `pend` and sets `pflag`. When a digit-0 slot begins with `pflag=1`, `pend` is copied into `act` and `pflag` clears.
  - If `load` coincides with the slot start, the copy uses the old `pend`. The new value lands in `pend` and `pflag` stays 1, so it is applied at the next frame.
  - Segments always display `act`.
- **Decode.** Nibble-to-segment mapping, active-low, with bits listed a..g:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- **Leading-zero suppression.** With `lzs=1`, digit i (i ≥ 1) is dark when nibbles i..DIGITS-1 of `act` are all zero. Digit 0 is never suppressed, so zero displays as "0".
- **Dark digit.** A digit is dark if it is blanked, suppressed, or `en=0`. A dark digit drives `seg=1111111`, `dp_n=1` and all `an_n` high for its whole slot.
  - `dp` of a dark digit is ignored.
  - The counter, `idx`, buffering and frame_start all continue.
- **Dead time.** In a slot for digit `idx` that is not dark:
  - for slot cycles 0..DEAD-1, `an_n` is all ones;
  - for cycles DEAD..REFRESH_DIV-1, `an_n[idx]=0`.
  - `seg` and `dp_n` show digit `idx` for the entire slot.

## Timing
- **Reset (asynchronous).**
  - Outputs: `seg=1111111`, `dp_n=1`, `an_n` all ones, `frame_start=0`.
  - Internal state: `cnt=0`, `idx=0`, `pend=0`, `act=0`, `pflag=0`.
  - Reset mid-slot or mid-load discards all pending data.
- **First slot.** The first cycle after reset release is slot cycle 0 of digit 0. `frame_start` is high in the output cycle for that slot cycle.
- **Output latency.** All outputs are registered and lag internal (`cnt`, `idx`) by one cycle.
  - Output cycle k of a slot corresponds to internal slot cycle k.
  - The first output cycle after reset release shows the reset values.
- **Load latency.** A load issued in any cycle appears on `seg` in the first output cycle of the next digit-0 slot whose start is strictly after the load edge.
- **Live controls.** `blank`, `dp`, `lzs` and `en` take effect on outputs one cycle after they change.
- **Rates.**
  - Frame period is DIGITS*REFRESH_DIV cycles.
  - Digit duty cycle is (REFRESH_DIV-DEAD)/(DIGITS*REFRESH_DIV).

## Test plan
All scenarios use DIGITS=4, REFRESH_DIV=8, DEAD=2.
1. Reset then `load` value=16'h1A3F, en=1 -> from the next frame, `an_n` goes 1110/1101/1011/0111 (low for 6 of 8 cycles per slot, all high for the first 2). `seg` reads 0111000, 0000110, 0001000, 1001111. `frame_start` has a period of 32 cycles.
2. Load 16'h0042 with lzs=1 -> digits 3 and 2 are dark (an_n stays 1111 in their slots). Digits 1 and 0 show 4 and 2. Load 16'h0000 -> only digit 0 lights, showing 0000001.
3. Loads of 16'h1111 and then 16'h2222 inside one frame, the second coinciding with frame_start -> the next frame shows 1111. The frame after that shows 2222. No frame mixes the two values.
4. blank=4'b0100, dp=4'b0101 -> digit 2 is dark with dp_n=1. Digit 0 shows dp_n=0. Digits 1 and 3 show dp_n=1.
5. en=0 for 20 cycles -> an_n=1111, seg=1111111 and dp_n=1 throughout, while frame_start keeps its 32-cycle period. After en returns to 1, the scan continues at the correct slot.
6. Assert rst_n low mid-slot with pflag set -> outputs immediately go to reset values. After release, all digits show 0 and the pending value is never displayed.
